// File: rtl/uart_rx_sampler_if.sv
// Serial-side bundle of the UART receive sampler: line and enable in,
// per-bit strobe, voted bit and frame status out.
interface uart_rx_sampler_if;
  logic rx_serial;
  logic en;
  logic rx_pulse;
  logic rx_bit;
  logic frame_active;
  logic framing_err;

  modport master (
    output rx_serial, en,
    input  rx_pulse, rx_bit, frame_active, framing_err
  );

  modport slave (
    input  rx_serial, en,
    output rx_pulse, rx_bit, frame_active, framing_err
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises the line, finds start edges, majority-votes
// each bit centre and emits one strobe per bit (start, 8 data, stop).
module uart_rx_sampler #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input logic              clk,
  input logic              rst,
  uart_rx_sampler_if.slave bus
);
  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam int H     = OVERSAMPLE / 2;

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_sampler: CLK_FREQ too low for BAUD*OVERSAMPLE");
  end
  if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_chk
    $error("uart_rx_sampler: OVERSAMPLE must be even and >= 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2, r_prev;
  logic [DIV_W-1:0] r_div_cnt;
  logic [IDX_W-1:0] r_tick_idx;
  logic             r_samp_a, r_samp_b;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic             r_pend;
  logic             r_pulse, r_bit, r_active, r_ferr;
  logic             w_pulse_nxt, w_bit_nxt, w_active_nxt, w_ferr_nxt;
  logic             w_fall, w_tick, w_dec, w_vote, w_accept;

  assign w_fall = ~r_sync2 & r_prev;
  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_dec  = w_tick && (r_tick_idx == IDX_W'(H + 1));
  assign w_vote = (r_samp_a & r_samp_b) | (r_samp_a & r_sync2) | (r_samp_b & r_sync2);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx_serial;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Bit timing restarts on every accepted start edge so the vote lands on the bit centre.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_div_cnt  <= '0;
      r_tick_idx <= '0;
    end else if (w_tick) begin
      r_div_cnt  <= '0;
      r_tick_idx <= (r_tick_idx == IDX_W'(OVERSAMPLE - 1)) ? '0 : r_tick_idx + IDX_W'(1);
    end else begin
      r_div_cnt  <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_a <= 1'b1;
      r_samp_b <= 1'b1;
    end else if (w_tick) begin
      if (r_tick_idx == IDX_W'(H - 1)) r_samp_a <= r_sync2;
      if (r_tick_idx == IDX_W'(H))     r_samp_b <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_pend    <= 1'b0;
      r_pulse   <= 1'b0;
      r_bit     <= 1'b1;
      r_active  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_pend    <= (r_state == S_STOP) && w_dec && w_fall;
      r_pulse   <= w_pulse_nxt;
      r_bit     <= w_bit_nxt;
      r_active  <= w_active_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_accept      = 1'b0;
    w_pulse_nxt   = 1'b0;
    w_bit_nxt     = r_bit;
    w_active_nxt  = r_active;
    w_ferr_nxt    = 1'b0;
    if (!bus.en) begin
      w_state_nxt  = S_IDLE;
      w_active_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall || r_pend) begin
            w_accept     = 1'b1;
            w_state_nxt  = S_START;
            w_active_nxt = 1'b1;
          end
        end
        S_START: begin
          if (w_dec) begin
            if (!w_vote) begin
              w_pulse_nxt   = 1'b1;
              w_bit_nxt     = 1'b0;
              w_bit_cnt_nxt = '0;
              w_state_nxt   = S_DATA;
            end else begin
              w_state_nxt  = S_IDLE;
              w_active_nxt = 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_dec) begin
            w_pulse_nxt   = 1'b1;
            w_bit_nxt     = w_vote;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
          end
        end
        S_STOP: begin
          if (w_dec) begin
            w_pulse_nxt  = 1'b1;
            w_bit_nxt    = w_vote;
            w_ferr_nxt   = ~w_vote;
            w_active_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.rx_pulse     = r_pulse;
  assign bus.rx_bit       = r_bit;
  assign bus.frame_active = r_active;
  assign bus.framing_err  = r_ferr;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: frames are driven bit by bit while a
// scoreboard of expected strobes is checked by a negedge monitor.
module tb_uart_rx_sampler;
  localparam int CLK_FREQ   = 3_200_000;
  localparam int BAUD       = 100_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = 32;

  typedef struct packed {
    logic b;
    logic ferr;
    logic last;
    logic first;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  uart_rx_sampler_if bus ();

  uart_rx_sampler #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_pulses = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  bit   mon_on   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int k = 0;
    while (n_pulses < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("pulse_wait", n_pulses >= target, 1);
  endtask

  task automatic expect_drained(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  task automatic send_slot(input logic v, input bit spike);
    bus.rx_serial = v;
    if (spike) begin
      // Sample at tick H sees the line as it was 19 clks into the bit.
      wait_clks(18);
      bus.rx_serial = ~v;
      wait_clks(1);
      bus.rx_serial = v;
      wait_clks(BIT_CLKS - 19);
    end else begin
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int n_push,
                            input int spike_bit, input bit chk_active);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i < n_push) begin
        e.b     = bits[i];
        e.ferr  = (i == 9) && !stop;
        e.last  = (i == 9);
        e.first = (i == 0);
        exp_q.push_back(e);
      end
    end
    send_slot(bits[0], 1'b0);
    if (chk_active) check("active_in_frame", bus.frame_active, 1);
    for (int i = 1; i < 10; i++) send_slot(bits[i], (i - 1) == spike_bit);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mon_on) begin
      if (bus.rx_pulse === 1'b1) begin
        n_pulses++;
        check("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rx_bit", bus.rx_bit, e.b);
          check("framing_err_at_strobe", bus.framing_err, e.ferr);
          check("frame_active_at_strobe", bus.frame_active, !e.last);
          if (!e.first) check("strobe_spacing", cyc - last_cyc, BIT_CLKS);
          last_cyc = cyc;
        end
      end else begin
        check("framing_err_idle", bus.framing_err, 0);
      end
    end
  end

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst           = 1'b1;
    bus.en        = 1'b1;
    bus.rx_serial = 1'b1;
    wait_clks(3);
    check("reset_pulse", bus.rx_pulse, 0);
    check("reset_bit", bus.rx_bit, 1);
    check("reset_active", bus.frame_active, 0);
    check("reset_ferr", bus.framing_err, 0);
    rst    = 1'b0;
    mon_on = 1'b1;
    wait_clks(10);

    // 1) clean 0xA5 frame
    p0 = n_pulses;
    send_frame(8'hA5, 1'b1, 10, -1, 1'b1);
    expect_drained("a5_drained");
    check("a5_count", n_pulses, p0 + 10);
    check("a5_active_after", bus.frame_active, 0);
    wait_clks(20);

    // 2) 8-clk low glitch is a false start
    p0 = n_pulses;
    bus.rx_serial = 1'b0;
    wait_clks(8);
    bus.rx_serial = 1'b1;
    check("glitch_active_rise", bus.frame_active, 1);
    wait_clks(30);
    check("glitch_active_clear", bus.frame_active, 0);
    check("glitch_no_strobe", n_pulses, p0);
    wait_clks(20);

    // 3) 0x00 with stop=0, then line held low as a break
    p0 = n_pulses;
    send_frame(8'h00, 1'b0, 10, -1, 1'b1);
    wait_clks(100);
    check("break_drained", exp_q.size(), 0);
    check("break_count", n_pulses, p0 + 10);
    check("break_active", bus.frame_active, 0);
    bus.rx_serial = 1'b1;
    wait_clks(40);
    check("break_no_retrigger", n_pulses, p0 + 10);

    // 4) en dropped after the 4th strobe, then a clean 0x3C
    p0 = n_pulses;
    fork
      send_frame(8'hC3, 1'b1, 4, -1, 1'b1);
      begin
        wait_pulses(p0 + 4, 400);
        wait_clks(5);
        bus.en = 1'b0;
        wait_clks(1);
        check("en_drop_active", bus.frame_active, 0);
      end
    join
    wait_clks(40);
    check("en_drop_no_more", n_pulses, p0 + 4);
    check("en_drop_drained", exp_q.size(), 0);
    bus.en = 1'b1;
    wait_clks(10);
    p0 = n_pulses;
    send_frame(8'h3C, 1'b1, 10, -1, 1'b1);
    expect_drained("reenable_drained");
    check("reenable_count", n_pulses, p0 + 10);
    wait_clks(20);

    // 5) 1-clk spike on data bit 2 is outvoted
    p0 = n_pulses;
    send_frame(8'h00, 1'b1, 10, 2, 1'b1);
    expect_drained("spike_drained");
    check("spike_count", n_pulses, p0 + 10);
    wait_clks(20);

    // 6) reset mid-DATA of 0xFF, then two back-to-back 0x55 frames
    p0 = n_pulses;
    fork
      send_frame(8'hFF, 1'b1, 1, -1, 1'b0);
      begin
        wait_pulses(p0 + 1, 200);
        wait_clks(12);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check("midrst_pulse", bus.rx_pulse, 0);
        check("midrst_bit", bus.rx_bit, 1);
        check("midrst_active", bus.frame_active, 0);
        check("midrst_ferr", bus.framing_err, 0);
      end
    join
    check("midrst_count", n_pulses, p0 + 1);
    wait_clks(10);
    p0 = n_pulses;
    send_frame(8'h55, 1'b1, 10, -1, 1'b1);
    send_frame(8'h55, 1'b1, 10, -1, 1'b1);
    expect_drained("b2b_drained");
    check("b2b_count", n_pulses, p0 + 20);
    wait_clks(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
